branch_redirect_fetch_unit: RTL and testbench

- Fetch-side PC unit that consumes the branch predictor's outputs (`signal_to_take_branch`, `flush`).
- Holds the program counter and an 8-entry direct-mapped branch target buffer (BTB).
- Steers the next PC:
  - to the BTB target when a branch in ID is predicted taken and the BTB hits;
  - to the ALU-resolved recovery address on a misprediction flush.
- Also produces the squash signal for the IF/ID register.

---
 rtl/branch_redirect_fetch_unit.sv | 104 ++++++++++
 tb/tb_branch_redirect_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_fetch_unit.sv
// Fetch PC register with an 8-entry direct-mapped BTB.
// Redirects on predicted-taken BTB hits and on misprediction flushes.
module branch_redirect_fetch_unit #(
    parameter int          ENTRIES  = 8,
    parameter int          INDEX_W  = 3,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        stall,
    input  logic        ID_stage_branch,
    input  logic        signal_to_take_branch,
    input  logic [31:0] ID_pc,
    input  logic        ALU_stage_branch,
    input  logic        ALU_stage_branch_result,
    input  logic [31:0] ALU_pc,
    input  logic [31:0] ALU_branch_target,
    input  logic        flush,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_4,
    output logic        btb_hit,
    output logic        if_id_squash
);

    localparam int TAG_W = 32 - INDEX_W - 2;

    logic [31:0]        pc_q, pc_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [INDEX_W-1:0] id_idx;
    logic [TAG_W-1:0]   id_tag;
    logic [INDEX_W-1:0] alu_idx;
    logic [TAG_W-1:0]   alu_tag;
    logic               redirect;
    logic [31:0]        flush_pc;

    // Byte-offset bits of the ID PC play no part in the BTB lookup.
    logic unused_id_pc_lo;
    assign unused_id_pc_lo = ^ID_pc[1:0];

    assign id_idx  = ID_pc[INDEX_W+1:2];
    assign id_tag  = ID_pc[31:INDEX_W+2];
    assign alu_idx = ALU_pc[INDEX_W+1:2];
    assign alu_tag = ALU_pc[31:INDEX_W+2];

    assign PC        = pc_q;
    assign PC_plus_4 = pc_q + 32'd4;

    always_comb begin
        btb_hit      = ID_stage_branch && valid_q[id_idx] && (tag_q[id_idx] == id_tag);
        redirect     = ID_stage_branch && signal_to_take_branch && btb_hit;
        if_id_squash = flush || (redirect && !stall);
        flush_pc     = ALU_stage_branch_result ? ALU_branch_target : (ALU_pc + 32'd4);

        if (flush) begin
            pc_d = flush_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            pc_d = target_q[id_idx];
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Only taken resolutions train the BTB; the lookup above sees pre-edge contents.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < ENTRIES; i++) begin
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
        end
        if (ALU_stage_branch && ALU_stage_branch_result) begin
            valid_d[alu_idx]  = 1'b1;
            tag_d[alu_idx]    = alu_tag;
            target_d[alu_idx] = ALU_branch_target;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Tag and target storage needs no reset; valid bits gate its use.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_fetch_unit.sv
// Directed bench for branch_redirect_fetch_unit with hand-computed PC and BTB expectations.
module tb_branch_redirect_fetch_unit;

    logic        CLK;
    logic        reset;
    logic        stall;
    logic        ID_stage_branch;
    logic        signal_to_take_branch;
    logic [31:0] ID_pc;
    logic        ALU_stage_branch;
    logic        ALU_stage_branch_result;
    logic [31:0] ALU_pc;
    logic [31:0] ALU_branch_target;
    logic        flush;
    logic [31:0] PC;
    logic [31:0] PC_plus_4;
    logic        btb_hit;
    logic        if_id_squash;

    int checks   = 0;
    int failures = 0;

    branch_redirect_fetch_unit dut (
        .CLK                     (CLK),
        .reset                   (reset),
        .stall                   (stall),
        .ID_stage_branch         (ID_stage_branch),
        .signal_to_take_branch   (signal_to_take_branch),
        .ID_pc                   (ID_pc),
        .ALU_stage_branch        (ALU_stage_branch),
        .ALU_stage_branch_result (ALU_stage_branch_result),
        .ALU_pc                  (ALU_pc),
        .ALU_branch_target       (ALU_branch_target),
        .flush                   (flush),
        .PC                      (PC),
        .PC_plus_4               (PC_plus_4),
        .btb_hit                 (btb_hit),
        .if_id_squash            (if_id_squash)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        stall                   = 1'b0;
        ID_stage_branch         = 1'b0;
        signal_to_take_branch   = 1'b0;
        ID_pc                   = 32'h0;
        ALU_stage_branch        = 1'b0;
        ALU_stage_branch_result = 1'b0;
        ALU_pc                  = 32'h0;
        ALU_branch_target       = 32'h0;
        flush                   = 1'b0;
    endtask

    task automatic id_branch(input logic [31:0] pc);
        ID_stage_branch       = 1'b1;
        signal_to_take_branch = 1'b1;
        ID_pc                 = pc;
    endtask

    task automatic alu_taken(input logic [31:0] pc, input logic [31:0] tgt);
        ALU_stage_branch        = 1'b1;
        ALU_stage_branch_result = 1'b1;
        ALU_pc                  = pc;
        ALU_branch_target       = tgt;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        flush = 1'b1;
        ALU_stage_branch_result = 1'b1;
        ALU_branch_target = 32'h0000_0500;

        // 1: reset dominates a pending flush
        tick();
        check("rst_pc0", PC, 32'h0);
        tick();
        check("rst_pc1", PC, 32'h0);
        check("rst_hit", {31'b0, btb_hit}, 32'h0);
        idle();
        reset = 1'b1;
        #1;
        check("rst_squash", {31'b0, if_id_squash}, 32'h0);
        check("rel_pc0", PC, 32'h0);
        check("rel_pc4", PC_plus_4, 32'h4);
        tick();
        check("rel_pc1", PC, 32'h4);
        tick();
        check("rel_pc2", PC, 32'h8);

        // 2: cold miss, train, then hit
        id_branch(32'h10);
        #1;
        check("cold_hit", {31'b0, btb_hit}, 32'h0);
        check("cold_sq", {31'b0, if_id_squash}, 32'h0);
        tick();
        check("cold_pc", PC, 32'hC);
        idle();
        alu_taken(32'h10, 32'h40);
        tick();
        check("train_pc", PC, 32'h10);
        idle();
        ID_pc = 32'h10;
        #1;
        check("no_id_hit", {31'b0, btb_hit}, 32'h0);
        id_branch(32'h10);
        #1;
        check("warm_hit", {31'b0, btb_hit}, 32'h1);
        check("warm_sq", {31'b0, if_id_squash}, 32'h1);
        tick();
        check("warm_pc", PC, 32'h40);
        idle();

        // 3: mispredict recovery, not-taken then taken
        flush  = 1'b1;
        ALU_stage_branch = 1'b1;
        ALU_pc = 32'h40;
        #1;
        check("fl_nt_sq", {31'b0, if_id_squash}, 32'h1);
        tick();
        check("fl_nt_pc", PC, 32'h44);
        alu_taken(32'h40, 32'h100);
        tick();
        check("fl_t_pc", PC, 32'h100);
        idle();

        // 4: flush beats stall and an ID hit
        alu_taken(32'h20, 32'h80);
        tick();
        check("tr20_pc", PC, 32'h104);
        idle();
        flush  = 1'b1;
        stall  = 1'b1;
        ALU_pc = 32'h200;
        id_branch(32'h20);
        #1;
        check("pri_hit", {31'b0, btb_hit}, 32'h1);
        check("pri_sq", {31'b0, if_id_squash}, 32'h1);
        tick();
        check("pri_pc", PC, 32'h204);
        idle();

        // 5: stall holds PC and suppresses the redirect
        flush = 1'b1;
        ALU_stage_branch_result = 1'b1;
        ALU_branch_target = 32'h20;
        tick();
        check("st_setup", PC, 32'h20);
        idle();
        stall = 1'b1;
        id_branch(32'h20);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_hit", {31'b0, btb_hit}, 32'h1);
            check("st_sq", {31'b0, if_id_squash}, 32'h0);
            tick();
            check("st_pc", PC, 32'h20);
        end
        stall = 1'b0;
        #1;
        check("unst_sq", {31'b0, if_id_squash}, 32'h1);
        tick();
        check("unst_pc", PC, 32'h80);
        idle();

        // 6a: aliasing; same-cycle write is invisible to the lookup
        id_branch(32'h10);
        alu_taken(32'h30, 32'h300);
        #1;
        check("al_old_hit", {31'b0, btb_hit}, 32'h1);
        tick();
        check("al_old_pc", PC, 32'h40);
        idle();
        id_branch(32'h10);
        #1;
        check("al_10_miss", {31'b0, btb_hit}, 32'h0);
        check("al_10_sq", {31'b0, if_id_squash}, 32'h0);
        id_branch(32'h30);
        #1;
        check("al_30_hit", {31'b0, btb_hit}, 32'h1);
        tick();
        check("al_30_pc", PC, 32'h300);
        idle();

        // 6b: 32-bit wrap
        flush = 1'b1;
        ALU_stage_branch_result = 1'b1;
        ALU_branch_target = 32'hFFFF_FFFC;
        tick();
        check("wr_pc", PC, 32'hFFFF_FFFC);
        idle();
        #1;
        check("wr_p4", PC_plus_4, 32'h0);
        tick();
        check("wr_next", PC, 32'h0);
        flush  = 1'b1;
        ALU_pc = 32'hFFFF_FFFC;
        tick();
        check("wr_fl", PC, 32'h0);
        idle();

        // reset mid-redirect clears PC and BTB valids
        reset = 1'b0;
        id_branch(32'h30);
        flush = 1'b1;
        ALU_stage_branch_result = 1'b1;
        ALU_branch_target = 32'h700;
        tick();
        check("rst2_pc", PC, 32'h0);
        idle();
        reset = 1'b1;
        id_branch(32'h30);
        #1;
        check("rst2_hit", {31'b0, btb_hit}, 32'h0);
        tick();
        check("rst2_next", PC, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
